// File: rtl/seq_arr_mul.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock, behind valid/ready.
// Supports unsigned or two's-complement operands selected at accept time.
module seq_arr_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    // One-hot so that every status output is a single register bit
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_CALC = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]       state_q,  state_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             sgn_q,    sgn_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [PW-1:0]    out_q,    out_d;

    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_sum;
    logic             last_bit;

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sgn_d    = sgn_q;
        cnt_d    = cnt_q;
        out_d    = out_q;

        addend   = mplier_q[0] ? mcand_q : '0;
        last_bit = (cnt_q == CW'(WIDTH - 1));
        // Top multiplier bit carries negative weight in signed mode
        acc_sum  = (sgn_q && last_bit) ? (acc_q - addend) : (acc_q + addend);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sgn_d    = is_signed;
                    mcand_d  = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if ((a == '0) || (b == '0)) begin
                        state_d = S_DONE;
                        out_d   = '0;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = S_DONE;
                    out_d   = acc_sum;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sgn_q    <= 1'b0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sgn_q    <= sgn_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign in_ready  = state_q[0];
    assign out_valid = state_q[2];
    assign busy      = ~state_q[0];
    assign out       = out_q;

endmodule

// File: tb/tb_seq_arr_mul.sv
// Self-checking bench for seq_arr_mul: WIDTH=2, 4 and 8 instances, directed table,
// multi-cycle corner sequences and randomized operands against an integer product model.
module tb_seq_arr_mul;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       in_valid  [3];
    logic       out_ready [3];
    logic       sgn       [3];
    logic [7:0] a_v       [3];
    logic [7:0] b_v       [3];

    wire        in_ready_w  [3];
    wire        out_valid_w [3];
    wire        busy_w      [3];
    wire [15:0] out_w       [3];

    logic [15:0] last_out [3];

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_arr_mul #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .a(a_v[0][1:0]), .b(b_v[0][1:0]), .is_signed(sgn[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready[0]), .out(out_w[0][3:0]), .busy(busy_w[0])
    );
    assign out_w[0][15:4] = '0;

    seq_arr_mul #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .a(a_v[1][3:0]), .b(b_v[1][3:0]), .is_signed(sgn[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready[1]), .out(out_w[1][7:0]), .busy(busy_w[1])
    );
    assign out_w[1][15:8] = '0;

    seq_arr_mul #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .a(a_v[2]), .b(b_v[2]), .is_signed(sgn[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready[2]), .out(out_w[2]), .busy(busy_w[2])
    );

    typedef struct {
        int          k;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
        int          stall;
    } vec_t;

    function automatic int wid(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 8);
    endfunction

    // Golden product: interpret operands as integers, multiply, wrap to 2*w bits
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x,
                                            input logic [7:0] y, input logic s);
        longint m, xv, yv, p;
        m  = longint'(1) << w;
        xv = longint'(x) % m;
        yv = longint'(y) % m;
        if (s && (xv >= m / 2)) xv = xv - m;
        if (s && (yv >= m / 2)) yv = yv - m;
        p = (xv * yv) % (m * m);
        if (p < 0) p = p + m * m;
        return 16'(p);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_in_ready", longint'(in_ready_w[k]), 1);
        chk("rst_out_valid", longint'(out_valid_w[k]), 0);
        chk("rst_busy", longint'(busy_w[k]), 0);
        chk("rst_out", longint'(out_w[k]), 0);
    endtask

    // One full transaction with latency, hold, stall and return-to-idle checks
    task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input logic [15:0] exp, input int stall);
        int         w;
        int         n;
        int         exp_lat;
        logic [7:0] m8;
        w  = wid(k);
        m8 = 8'((1 << w) - 1);
        exp_lat = (((x & m8) == 8'd0) || ((y & m8) == 8'd0)) ? 1 : w + 1;

        n = 0;
        while (!in_ready_w[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", longint'(in_ready_w[k]), 1);

        a_v[k] = x; b_v[k] = y; sgn[k] = s;
        in_valid[k]  = 1'b1;
        out_ready[k] = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!out_valid_w[k] && n < 40) begin
            chk("calc_in_ready", longint'(in_ready_w[k]), 0);
            chk("calc_busy", longint'(busy_w[k]), 1);
            chk("calc_out_hold", longint'(out_w[k]), longint'(last_out[k]));
            in_valid[k] = 1'($urandom);
            a_v[k] = 8'($urandom); b_v[k] = 8'($urandom); sgn[k] = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("product", longint'(out_w[k]), longint'(exp));
        chk("done_in_ready", longint'(in_ready_w[k]), 0);
        last_out[k] = exp;

        for (int i = 0; i < stall; i++) begin
            in_valid[k] = 1'($urandom);
            a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", longint'(out_valid_w[k]), 1);
            chk("stall_out", longint'(out_w[k]), longint'(exp));
        end

        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_valid", longint'(out_valid_w[k]), 0);
        chk("post_hs_ready", longint'(in_ready_w[k]), 1);
        chk("post_hs_busy", longint'(busy_w[k]), 0);
        chk("post_hs_out", longint'(out_w[k]), longint'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   n;

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1; sgn[k] = 1'b0;
            a_v[k] = 8'd0; b_v[k] = 8'd0; last_out[k] = 16'd0;
        end
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset_outputs(k);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{1, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 0});
        vecs.push_back('{1, 8'h08, 8'h08, 1'b1, 16'h0040, 0});
        vecs.push_back('{1, 8'h08, 8'h07, 1'b1, 16'h00C8, 1});
        vecs.push_back('{1, 8'h03, 8'h0F, 1'b1, 16'h00FD, 0});
        vecs.push_back('{2, 8'h00, 8'hA5, 1'b0, 16'h0000, 0});
        vecs.push_back('{2, 8'h7F, 8'h00, 1'b0, 16'h0000, 0});
        vecs.push_back('{2, 8'hC8, 8'h64, 1'b0, 16'h4E20, 6});
        vecs.push_back('{2, 8'h80, 8'h80, 1'b1, 16'h4000, 2});
        vecs.push_back('{2, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0});
        vecs.push_back('{2, 8'hFF, 8'h02, 1'b1, 16'hFFFE, 0});
        vecs.push_back('{0, 8'h02, 8'h02, 1'b1, 16'h0004, 0});
        vecs.push_back('{0, 8'h03, 8'h03, 1'b0, 16'h0009, 3});
        foreach (vecs[i])
            run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].stall);

        // Reset three edges into CALC discards the operation
        a_v[2] = 8'h55; b_v[2] = 8'h33; sgn[2] = 1'b0; in_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", longint'(busy_w[2]), 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs(2);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last_out[k] = 16'd0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_w[2]) n++;
        end
        chk("no_valid_after_rst", n, 0);
        run_op(2, 8'd6, 8'd7, 1'b0, 16'd42, 0);

        // Exhaustive sweep for the narrow instances
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 2; s++)
                for (int x = 0; x < (1 << wid(k)); x++)
                    for (int y = 0; y < (1 << wid(k)); y++)
                        run_op(k, 8'(x), 8'(y), 1'(s),
                               ref_mul(wid(k), 8'(x), 8'(y), 1'(s)),
                               $urandom_range(0, 3));

        // Random operands on the wide instance
        for (int i = 0; i < 200; i++) begin
            logic [7:0] x, y;
            logic       s;
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
            if (i % 17 == 0) x = 8'd0;
            run_op(2, x, y, s, ref_mul(8, x, y, s), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
